// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the DRAM port arbiter.
//   load_store_func_code : width/sign code forwarded to DRAM with each access
//   ARB_IF_OPERATOR      : code used for instruction fetches (word load)
//   arb_state_e          : arbiter FSM states
package mem_port_arbiter_pkg;

    typedef logic [3:0] load_store_func_code;

    localparam load_store_func_code LSF_LB  = 4'd0;
    localparam load_store_func_code LSF_LH  = 4'd1;
    localparam load_store_func_code LSF_LW  = 4'd2;
    localparam load_store_func_code LSF_LBU = 4'd4;
    localparam load_store_func_code LSF_LHU = 4'd5;
    localparam load_store_func_code LSF_SB  = 4'd8;
    localparam load_store_func_code LSF_SH  = 4'd9;
    localparam load_store_func_code LSF_SW  = 4'd10;

    localparam load_store_func_code ARB_IF_OPERATOR = LSF_LW;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_BUSY_IF  = 2'd1,
        ARB_BUSY_LSU = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single DRAM port between instruction fetch (IF) and the
// load/store unit (LSU). One transaction outstanding at most; LSU has priority
// unless IF has been denied STARVE_LIMIT consecutive arbitrations.
// Ports:
//   clock, reset                 : clock, async active-high reset
//   if_req/addr/flush_ip         : fetch request, address, redirect flush
//   if_gnt/rvalid/rdata_op       : fetch accept and response
//   lsu_req/we/operator/addr/wdata_ip : load/store request
//   lsu_gnt/rvalid/rdata_op      : load/store accept and response
//   mem_*_op                     : DRAM request side
//   mem_rvalid_ip, mem_rdata_ip  : DRAM response
//   spurious_op                  : sticky flag, DRAM response with nothing in flight
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                if_req_ip,
    input  logic [ADDR_W-1:0]   if_addr_ip,
    input  logic                if_flush_ip,
    output logic                if_gnt_op,
    output logic                if_rvalid_op,
    output logic [DATA_W-1:0]   if_rdata_op,
    input  logic                lsu_req_ip,
    input  logic                lsu_we_ip,
    input  load_store_func_code lsu_operator_ip,
    input  logic [ADDR_W-1:0]   lsu_addr_ip,
    input  logic [DATA_W-1:0]   lsu_wdata_ip,
    output logic                lsu_gnt_op,
    output logic                lsu_rvalid_op,
    output logic [DATA_W-1:0]   lsu_rdata_op,
    output logic                mem_req_op,
    output logic                mem_we_op,
    output load_store_func_code mem_operator_op,
    output logic [ADDR_W-1:0]   mem_addr_op,
    output logic [DATA_W-1:0]   mem_wdata_op,
    input  logic                mem_rvalid_ip,
    input  logic [DATA_W-1:0]   mem_rdata_ip,
    output logic                spurious_op
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_e     state;
    arb_state_e     state_nxt;
    logic [SW-1:0]  starve_cnt;
    logic           discard;
    logic           lsu_store_q;
    logic           arb_cycle;
    logic           if_win;
    logic           lsu_win;
    logic           resp;

    // The port is free when idle, or when the outstanding response arrives
    // this cycle, which allows back-to-back grants.
    assign resp      = (state != ARB_IDLE) && mem_rvalid_ip;
    assign arb_cycle = (state == ARB_IDLE) || resp;
    assign if_win    = arb_cycle && if_req_ip && (!lsu_req_ip || (starve_cnt == STARVE_MAX));
    assign lsu_win   = arb_cycle && lsu_req_ip && !if_win;

    always_comb begin
        if_gnt_op       = if_win;
        lsu_gnt_op      = lsu_win;
        mem_req_op      = if_win || lsu_win;
        mem_we_op       = lsu_win && lsu_we_ip;
        mem_operator_op = '0;
        mem_addr_op     = '0;
        mem_wdata_op    = '0;
        if (lsu_win) begin
            mem_operator_op = lsu_operator_ip;
            mem_addr_op     = lsu_addr_ip;
            mem_wdata_op    = lsu_wdata_ip;
        end else if (if_win) begin
            mem_operator_op = ARB_IF_OPERATOR;
            mem_addr_op     = if_addr_ip;
        end
    end

    // A flush arriving with the response suppresses it just like a stored discard.
    always_comb begin
        if_rvalid_op  = (state == ARB_BUSY_IF) && mem_rvalid_ip && !discard && !if_flush_ip;
        lsu_rvalid_op = (state == ARB_BUSY_LSU) && mem_rvalid_ip;
        if_rdata_op   = if_rvalid_op ? mem_rdata_ip : '0;
        lsu_rdata_op  = (lsu_rvalid_op && !lsu_store_q) ? mem_rdata_ip : '0;
    end

    always_comb begin
        state_nxt = state;
        if (arb_cycle) begin
            if (if_win)
                state_nxt = ARB_BUSY_IF;
            else if (lsu_win)
                state_nxt = ARB_BUSY_LSU;
            else
                state_nxt = ARB_IDLE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ARB_IDLE;
            starve_cnt  <= '0;
            discard     <= 1'b0;
            lsu_store_q <= 1'b0;
            spurious_op <= 1'b0;
        end else begin
            state <= state_nxt;

            if (lsu_win)
                lsu_store_q <= lsu_we_ip;

            if (if_win)
                starve_cnt <= '0;
            else if (lsu_win && if_req_ip && (starve_cnt != STARVE_MAX))
                starve_cnt <= starve_cnt + 1'b1;

            // Discard belongs to the in-flight fetch only; it is retired with that
            // response even if a new fetch is granted in the same cycle.
            if (state == ARB_BUSY_IF) begin
                if (mem_rvalid_ip)
                    discard <= 1'b0;
                else if (if_flush_ip)
                    discard <= 1'b1;
            end

            if ((state == ARB_IDLE) && mem_rvalid_ip)
                spurious_op <= 1'b1;
        end
    end

endmodule
